// File: rtl/aes128_enc_ctrl_pkg.sv
// Shared AES-128 definitions for the encryption controller and its round
// datapath: FSM state encoding, round constants, GF(2^8) helpers, the S-box
// and the ShiftRows byte permutation.
//
// Core state layout: byte k sits at [8k+7:8k]. Bytes are column-major, so
// byte k is row (k % 4), column (k / 4).
package aes128_enc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] AES_POLY   = 8'h1b;
  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // S-box computed as affine(x^254); x^254 is the multiplicative inverse and
  // maps 0 to 0, which is what the S-box definition needs.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Row r rotates left by r columns: out(r, c) = in(r, (c + r) % 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
    return o;
  endfunction

  // Port order (byte 0 at [127:120]) <-> core order (byte 0 at [7:0]).
  function automatic logic [127:0] swap_bytes(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int k = 0; k < 16; k++)
      y[8*k +: 8] = x[127-8*k -: 8];
    return y;
  endfunction

endpackage

// File: rtl/aes128_enc_ctrl_aes_round.sv
// Combinational AES-128 round: expands the current round key by one step and
// applies SubBytes, ShiftRows, optional MixColumns and AddRoundKey using the
// freshly expanded key. Everything is in core byte layout.
//
// Ports:
//   i_state  current cipher state
//   i_rk     current round key
//   i_rcon   round constant for this expansion step
//   i_mix    1 = apply MixColumns (all rounds but the last)
//   o_state  state after the round
//   o_rk     expanded round key used by this round
module aes_round
  import aes128_enc_ctrl_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  input  logic         i_mix,
  output logic [127:0] o_state,
  output logic [127:0] o_rk
);

  // Word i is bytes 4i..4i+3; within a word, FIPS byte j sits at [8j+7:8j].
  function automatic logic [127:0] key_expand(input logic [127:0] rk,
                                              input logic [7:0]   rcon);
    logic [31:0] w0, w1, w2, w3, t;
    w3 = rk[127:96];
    // RotWord moves FIPS byte 1 to byte 0, i.e. a right rotate here.
    t  = {w3[7:0], w3[31:8]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    t  = t ^ {24'h0, rcon};
    w0 = rk[31:0]   ^ t;
    w1 = rk[63:32]  ^ w0;
    w2 = rk[95:64]  ^ w1;
    w3 = rk[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] st,
                                            input logic [127:0] rk,
                                            input logic         mix);
    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    sb = '0;
    for (int k = 0; k < 16; k++)
      sb[8*k +: 8] = sbox(st[8*k +: 8]);
    sr  = shift_rows(sb);
    res = sr;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[8*(4*c)   +: 8];
        a1 = sr[8*(4*c+1) +: 8];
        a2 = sr[8*(4*c+2) +: 8];
        a3 = sr[8*(4*c+3) +: 8];
        res[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        res[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        res[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        res[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return res ^ rk;
  endfunction

  assign o_rk    = key_expand(i_rk, i_rcon);
  assign o_state = round_fn(i_state, o_rk, i_mix);

endmodule

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption controller. Takes one plaintext/key pair on a
// valid/ready input handshake, runs ten rounds (one per clock) through
// aes_round with on-the-fly key expansion, then holds the ciphertext on a
// valid/ready output handshake. No overlap between input and output.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     plaintext/key offered
//   in_ready     controller idle and able to accept
//   in_block     plaintext, FIPS-197 byte 0 at [127:120]
//   in_key       cipher key, FIPS-197 byte 0 at [127:120]
//   out_valid    ciphertext available
//   out_ready    consumer takes ciphertext
//   out_block    ciphertext, FIPS-197 byte 0 at [127:120]; 0 when not valid
//   busy         rounds in progress
//   round        current round index 0..10
module aes128_enc_ctrl
  import aes128_enc_ctrl_pkg::*;
#(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   round
);

  state_t       r_st;
  state_t       w_st_next;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic [127:0] w_state_next;
  logic [127:0] w_rk_next;
  logic         w_last;

  assign w_last = (r_round == LAST_ROUND);

  aes_round u_round (
    .i_state (r_state),
    .i_rk    (r_rk),
    .i_rcon  (r_rcon),
    .i_mix   (!w_last),
    .o_state (w_state_next),
    .o_rk    (w_rk_next)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // in this clock domain samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= ST_IDLE;
    else        r_st <= w_st_next;
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // w_st_next unassigned and infers a latch.
    w_st_next = r_st;
    case (r_st)
      ST_IDLE:  if (in_valid)  w_st_next = ST_ROUND;
      ST_ROUND: if (w_last)    w_st_next = ST_DONE;
      ST_DONE:  if (out_ready) w_st_next = ST_IDLE;
      default:                 w_st_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_block = '0;
    case (r_st)
      ST_IDLE:  in_ready = 1'b1;
      ST_ROUND: busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        out_block = swap_bytes(r_state);
      end
      default: ;
    endcase
  end

  assign round = r_round;

  // Datapath registers. The inputs are sampled only on the accept edge, so
  // in_block/in_key are free to change once the block is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_rk    <= '0;
      r_rcon  <= '0;
      r_round <= '0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= swap_bytes(in_block ^ in_key);
            r_rk    <= swap_bytes(in_key);
            r_rcon  <= RCON_INIT;
            r_round <= 4'd1;
          end
        end
        ST_ROUND: begin
          r_state <= w_state_next;
          r_rk    <= w_rk_next;
          r_rcon  <= xtime(r_rcon);
          if (!w_last) r_round <= r_round + 4'd1;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_round <= '0;
            if (ZEROIZE) begin
              r_state <= '0;
              r_rk    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Self-checking bench for aes128_enc_ctrl. Known-answer vectors from FIPS-197
// feed a scoreboard queue on acceptance; a negedge monitor pops and compares
// on each output handshake. A second instance with ZEROIZE=0 runs in
// lock-step to compare register retention after the final handshake.
module tb_aes128_enc_ctrl;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_block;
  logic         busy;
  logic [3:0]   round;

  logic         k_in_ready;
  logic         k_out_valid;
  logic [127:0] k_out_block;
  logic         k_busy;
  logic [3:0]   k_round;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = 0;
  int hs_edge = 0;
  int out_count = 0;
  int n;
  logic [127:0] exp_next;
  logic [127:0] sb_q[$];

  aes128_enc_ctrl #(.ZEROIZE(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy),
    .round     (round)
  );

  aes128_enc_ctrl #(.ZEROIZE(1'b0)) dut_keep (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (k_in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (k_out_valid),
    .out_ready (out_ready),
    .out_block (k_out_block),
    .busy      (k_busy),
    .round     (k_round)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] rev_bytes(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = x[127-8*k -: 8];
    return y;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait, returns on the negedge where out_valid is first seen.
  task automatic wait_out(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 40);
    check(tag, 128'(out_valid), 128'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 40);
    check(tag, 128'(in_ready), 128'd1);
  endtask

  // Scoreboard: push on acceptance, pop and compare on output handshake.
  // Inputs change only at posedge+1, so negedge sampling never races them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(exp_next);
        acc_edge = cyc + 1;
      end
      if (out_valid && out_ready) begin
        hs_edge = cyc + 1;
        out_count++;
        if (sb_q.size() == 0) check("sb_underflow", 128'(sb_q.size()), 128'd1);
        else                  check("ciphertext", out_block, sb_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    in_key    = '0;
    out_ready = 1'b0;
    exp_next  = '0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_round",     128'(round),     128'd0);
    check("rst_out_block", out_block,       128'd0);
    tick();
    rst_n = 1'b1;

    // FIPS-197 C.1 with latency measurement
    in_valid = 1'b1; in_block = C1_PT; in_key = C1_KEY; exp_next = C1_CT;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("c1_latency", 128'(n - 1), 128'd10);
    @(negedge clk);
    check("c1_in_ready_after", 128'(in_ready),  128'd1);
    check("c1_out_valid_drop", 128'(out_valid), 128'd0);

    // All-zero key/plaintext: round walk and busy width
    tick();
    in_valid = 1'b1; in_block = '0; in_key = '0; exp_next = Z_CT;
    tick();
    in_valid = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check("z_round", 128'(round), 128'(j));
      check("z_busy",  128'(busy),  128'd1);
    end
    @(negedge clk);
    check("z_busy_end",  128'(busy),      128'd0);
    check("z_out_valid", 128'(out_valid), 128'd1);
    check("z_round_max", 128'(round),     128'd10);
    wait_idle("z_idle");

    // Held in_valid while busy, inputs changed after acceptance, DONE stall
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_block = B_PT; in_key = B_KEY; exp_next = B_CT;
    tick();
    in_block = '0; in_key = '0; exp_next = Z_CT;
    wait_out("b_out_valid");
    check("b_single_accept", 128'(sb_q.size()), 128'd1);
    for (int i = 0; i < 20; i++) begin
      check("stall_out_valid", 128'(out_valid), 128'd1);
      check("stall_out_block", out_block,       B_CT);
      check("stall_in_ready",  128'(in_ready),  128'd0);
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("release_in_ready",  128'(in_ready),  128'd1);
    check("release_out_valid", 128'(out_valid), 128'd0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("second_accept_edge", 128'(acc_edge - hs_edge), 128'd1);
    wait_out("z2_out_valid");
    wait_idle("z2_idle");

    // Asynchronous reset at round 5, then a fresh C.1
    tick();
    in_valid = 1'b1; in_block = C1_PT; in_key = C1_KEY; exp_next = C1_CT;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (round != 4'd5 && n < 20);
    check("abort_round5", 128'(round), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready",  128'(in_ready),  128'd1);
    check("abort_busy",      128'(busy),      128'd0);
    check("abort_round",     128'(round),     128'd0);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_out_block", out_block,       128'd0);
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold_out_valid", 128'(out_valid), 128'd0);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_block = C1_PT; in_key = C1_KEY; exp_next = C1_CT;
    tick();
    in_valid = 1'b0;
    wait_out("c1b_out_valid");
    @(negedge clk);
    check("c1b_idle", 128'(in_ready), 128'd1);

    // Register clearing vs retention after the output handshake
    check("zeroize_state", dut.r_state,      128'd0);
    check("zeroize_rk",    dut.r_rk,         128'd0);
    check("retain_state",  dut_keep.r_state, rev_bytes(C1_CT));
    check("retain_rk",     dut_keep.r_rk,    rev_bytes(C1_RK10));

    check("output_count", 128'(out_count),   128'd5);
    check("sb_drained",   128'(sb_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_enc_ctrl.md
Name: aes128_enc_ctrl

Overview:
- Iterative AES-128 encryption controller. Accepts one plaintext/key pair over a valid/ready handshake.
- Sequences the round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) one round per clock, with on-the-fly key expansion.
- Presents the ciphertext on a valid/ready output handshake.
- Sits between the bus-side block interface and the combinational round logic; it is the only owner of the round datapath.

Parameters:
- ZEROIZE, 1, when 1 the state and round-key registers clear to 0 on return to IDLE; when 0 they hold their last value.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  plaintext/key offered.
- in_ready  output  1  controller can accept a block.
- in_block  input  128  plaintext; FIPS-197 byte 0 at [127:120].
- in_key  input  128  cipher key; FIPS-197 byte 0 at [127:120].
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer takes ciphertext.
- out_block  output  128  ciphertext; FIPS-197 byte 0 at [127:120].
- busy  output  1  encryption in progress (ROUND state).
- round  output  4  current round index 0..10, for debug and coverage.

Behaviour:
- Reset: rst_n is asynchronous and active low; clk is the only clock.
  - On assertion: state IDLE, in_ready=1, out_valid=0, busy=0, round=0, out_block=0, state and key registers 0.
  - Reset mid-operation aborts immediately. No partial result is ever presented.
- FSM states: IDLE, ROUND, DONE.
  - IDLE: in_ready=1.
    - On in_valid&&in_ready: state_reg <= in_block ^ in_key, rk_reg <= in_key, rcon_reg <= 8'h01, round <= 1, go to ROUND.
  - ROUND: in_ready=0, busy=1.
    - Each cycle: rk_next = expand(rk_reg, rcon_reg); state_reg <= round_fn(state_reg, rk_next, mix = (round != 10)); rk_reg <= rk_next; rcon_reg <= xtime(rcon_reg); round <= round+1.
    - When round==10 that cycle: go to DONE; round holds 10.
  - DONE: out_valid=1 and out_block = state_reg, both stable until the handshake completes.
    - On out_valid&&out_ready: go to IDLE with round <= 0; if ZEROIZE, state_reg/rk_reg <= 0.
- Latency:
  - Accept edge is edge N; out_valid=1 is visible after edge N+10.
  - in_ready returns 1 the cycle after the output handshake.
  - Throughput: one block per 12 cycles at best; there is no input/output overlap.
- Key expansion (AES-128):
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). After 8'h80, rcon becomes 8'h1b, then 8'h36.
- Byte ordering:
  - Ports use FIPS-197 big-endian order.
  - The controller maps port bytes to the core state layout, byte k at [8k+7:8k] (column-major, per constant.v), on input, and back on output.
  - The ShiftRows mapping is the shared core function, reused unchanged.
- Boundary conditions:
  - in_valid while busy or DONE is ignored; in_ready=0 and the inputs are not sampled.
  - out_ready held high with no out_valid has no effect.
  - out_ready low in DONE stalls indefinitely with output stable.
  - in_block/in_key may change after acceptance without affecting the result.
  - round never exceeds 10.

Decomposition:
- constant.v (shared include):
  - FSM state encodings (2-bit).
  - The RCON_INIT constant and the AES reduction polynomial 8'h1b.
  - The S-box table function and the xtime function.
- Sub-module aes_round: combinational round_fn (SubBytes, ShiftRows, conditional MixColumns, AddRoundKey) plus key expand.
- aes128_enc_ctrl: FSM, counters, rcon register and handshakes only.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after the accept edge.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e; round walks 1..10; busy high for exactly 10 cycles.
- in_valid held high with a second vector while busy -> second vector not taken until the cycle after the first output handshake; both ciphertexts correct, in order.
- out_ready held low 20 cycles in DONE -> out_valid and out_block stable throughout; in_ready stays 0; then one-cycle out_ready -> IDLE next cycle.
- rst_n pulsed low at round 5 -> all outputs reset asynchronously, no out_valid; a fresh FIPS C.1 vector afterwards yields the correct result.
- ZEROIZE=1: after the output handshake, internal state_reg/rk_reg read 0 (hierarchical check); ZEROIZE=0: they retain the last values.
